// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM port arbiter: FSM states and the fairness record.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_OWN   = 2'd1,
    WR_OWN   = 2'd2,
    RD_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/dram_outst_cnt.sv
// Outstanding-read counter: saturating up/down count with full/zero flags and an
// underflow pulse when a decrement arrives at zero.
module dram_outst_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         zero_o,
  output logic         underflow_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         inc_ok, dec_ok;

  assign zero_o      = (cnt_q == '0);
  assign full_o      = (cnt_q == W'(MAX));
  assign inc_ok      = inc_i & ~full_o;
  // A decrement at zero is reported but never wraps the count.
  assign dec_ok      = dec_i & ~zero_o;
  assign underflow_o = dec_i & zero_o;
  assign cnt_o       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_ok && !dec_ok)      cnt_d = cnt_q + W'(1);
    else if (!inc_ok && dec_ok) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one memory-controller command port between the read and write tile
// controllers; grants last a whole transaction and reads drain before handover.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W    = 34,
  parameter int DATA_W    = 512,
  parameter int MASK_W    = DATA_W/8,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              rd_cmd_val,
  input  logic [ADDR_W-1:0] rd_cmd_addr,
  output logic              rd_cmd_rdy,
  output logic              rd_resp_val,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req,
  input  logic              wr_cmd_val,
  input  logic [ADDR_W-1:0] wr_cmd_addr,
  input  logic [DATA_W-1:0] wr_cmd_data,
  input  logic [MASK_W-1:0] wr_cmd_mask,
  output logic              wr_cmd_rdy,
  output logic              mem_cmd_val,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_data,
  output logic [MASK_W-1:0] mem_cmd_mask,
  input  logic              mem_cmd_rdy,
  input  logic              mem_resp_val,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              grant_rd,
  output logic              grant_wr,
  output logic              err_unexp_resp
);

  arb_state_e       state_q, state_d;
  grant_e           last_q, last_d;
  logic             err_q;
  logic             rd_hs;
  logic [CNT_W-1:0] cnt;
  logic             cnt_full, cnt_zero, cnt_unf;

  dram_outst_cnt #(.MAX(MAX_OUTST), .W(CNT_W)) u_outst (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (rd_hs),
    .dec_i       (mem_resp_val),
    .cnt_o       (cnt),
    .full_o      (cnt_full),
    .zero_o      (cnt_zero),
    .underflow_o (cnt_unf)
  );

  // Read data is never blocked, not even during reset.
  assign rd_resp_val    = mem_resp_val;
  assign rd_resp_data   = mem_resp_data;
  assign grant_rd       = (state_q == RD_OWN);
  assign grant_wr       = (state_q == WR_OWN);
  assign err_unexp_resp = err_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rd_hs        = 1'b0;
    rd_cmd_rdy   = 1'b0;
    wr_cmd_rdy   = 1'b0;
    mem_cmd_val  = 1'b0;
    mem_cmd_wr   = 1'b0;
    mem_cmd_addr = '0;
    mem_cmd_data = '0;
    mem_cmd_mask = '0;
    case (state_q)
      IDLE: begin
        // Fairness only tracks contended rounds; uncontested grants leave it alone.
        if (rd_req && wr_req) begin
          if (last_q == GNT_WR) begin
            state_d = RD_OWN;
            last_d  = GNT_RD;
          end else begin
            state_d = WR_OWN;
            last_d  = GNT_WR;
          end
        end else if (rd_req) begin
          state_d = RD_OWN;
        end else if (wr_req) begin
          state_d = WR_OWN;
        end
      end
      RD_OWN: begin
        mem_cmd_val  = rd_cmd_val & ~cnt_full;
        mem_cmd_addr = rd_cmd_addr;
        rd_cmd_rdy   = mem_cmd_rdy & ~cnt_full;
        rd_hs        = rd_cmd_val & mem_cmd_rdy & ~cnt_full;
        // A read accepted on the releasing edge still has to be drained.
        if (!rd_req) state_d = ((cnt != '0) || rd_hs) ? RD_DRAIN : IDLE;
      end
      WR_OWN: begin
        mem_cmd_val  = wr_cmd_val;
        mem_cmd_wr   = 1'b1;
        mem_cmd_addr = wr_cmd_addr;
        mem_cmd_data = wr_cmd_data;
        mem_cmd_mask = wr_cmd_mask;
        wr_cmd_rdy   = mem_cmd_rdy;
        if (!wr_req) state_d = IDLE;
      end
      RD_DRAIN: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: begin
        rd_cmd_rdy   = 1'bx;
        wr_cmd_rdy   = 1'bx;
        mem_cmd_val  = 1'bx;
        mem_cmd_wr   = 1'bx;
        mem_cmd_addr = 'x;
        mem_cmd_data = 'x;
        mem_cmd_mask = 'x;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GNT_WR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_q | cnt_unf;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: a small memory model answers reads,
// expected commands/responses are queued when driven and checked on output.
module tb_dram_port_arbiter;
  localparam int ADDR_W = 34;
  localparam int DATA_W = 512;
  localparam int MASK_W = DATA_W/8;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } cmd_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } mresp_t;

  logic              clk, rst;
  logic              rd_req, rd_cmd_val, rd_cmd_rdy, rd_resp_val;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req, wr_cmd_val, wr_cmd_rdy;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [DATA_W-1:0] wr_cmd_data;
  logic [MASK_W-1:0] wr_cmd_mask;
  logic              mem_cmd_val, mem_cmd_wr, mem_cmd_rdy, mem_resp_val;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_data, mem_resp_data;
  logic [MASK_W-1:0] mem_cmd_mask;
  logic              grant_rd, grant_wr, err_unexp_resp;

  dram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_cmd_val(rd_cmd_val), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_rdy(rd_cmd_rdy), .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
    .wr_req(wr_req), .wr_cmd_val(wr_cmd_val), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_data(wr_cmd_data), .wr_cmd_mask(wr_cmd_mask), .wr_cmd_rdy(wr_cmd_rdy),
    .mem_cmd_val(mem_cmd_val), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_data(mem_cmd_data), .mem_cmd_mask(mem_cmd_mask), .mem_cmd_rdy(mem_cmd_rdy),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .grant_rd(grant_rd), .grant_wr(grant_wr), .err_unexp_resp(err_unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, n_rcmd = 0, n_rresp = 0;
  logic rd_hs, wr_hs, resp_hold, inject;
  cmd_t              exp_cmd[$];
  logic [DATA_W-1:0] exp_resp[$];
  mresp_t            mem_q[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdat(input logic [ADDR_W-1:0] a);
    rdat = {16{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  // One clock: sample at negedge, then advance the memory model after posedge.
  task automatic cyc();
    cmd_t   e;
    mresp_t m;
    @(negedge clk);
    rd_hs = rd_cmd_val && rd_cmd_rdy;
    wr_hs = wr_cmd_val && wr_cmd_rdy;
    if (mem_cmd_val && mem_cmd_rdy) begin
      if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        e = exp_cmd.pop_front();
        chk("cmd_wr", mem_cmd_wr, e.wr);
        chk("cmd_addr", mem_cmd_addr, e.addr);
        chk("cmd_data", mem_cmd_data, e.data);
        chk("cmd_mask", mem_cmd_mask, e.mask);
        if (!e.wr) begin
          n_rcmd++;
          m.due = cyc_n + 3;
          m.data = rdat(e.addr);
          mem_q.push_back(m);
        end
      end
    end
    if (inject) begin
      chk("resp_pass_val", rd_resp_val, 1);
      chk("resp_pass_data", rd_resp_data, mem_resp_data);
    end else if (rd_resp_val) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        chk("resp_data", rd_resp_data, exp_resp.pop_front());
        n_rresp++;
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
    if (inject) begin
      inject = 1'b0;
      mem_resp_val = 1'b0;
    end else if (!resp_hold && mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
      m = mem_q.pop_front();
      mem_resp_val  = 1'b1;
      mem_resp_data = m.data;
    end else begin
      mem_resp_val = 1'b0;
    end
  endtask

  task automatic drive_rd(input logic [ADDR_W-1:0] a);
    cmd_t e;
    rd_cmd_val = 1'b1;
    rd_cmd_addr = a;
    e.wr = 1'b0; e.addr = a; e.data = '0; e.mask = '0;
    exp_cmd.push_back(e);
    exp_resp.push_back(rdat(a));
  endtask

  task automatic rd_burst(input int n, input logic [ADDR_W-1:0] base, input int budget, output int got);
    got = 0;
    drive_rd(base);
    for (int i = 0; i < budget && got < n; i++) begin
      cyc();
      if (rd_hs) begin
        got++;
        if (got < n) drive_rd(base + ADDR_W'(got * 64));
        else rd_cmd_val = 1'b0;
      end
    end
    if (rd_cmd_val) begin
      rd_cmd_val = 1'b0;
      void'(exp_cmd.pop_back());
      void'(exp_resp.pop_back());
    end
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 30 && exp_resp.size() != 0; i++) cyc();
    chk(tag, exp_resp.size(), 0);
  endtask

  task automatic wr_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] mk);
    cmd_t e;
    wr_cmd_val = 1'b1; wr_cmd_addr = a; wr_cmd_data = d; wr_cmd_mask = mk;
    e.wr = 1'b1; e.addr = a; e.data = d; e.mask = mk;
    exp_cmd.push_back(e);
    wr_hs = 1'b0;
    for (int i = 0; i < 10 && !wr_hs; i++) cyc();
    chk("wr_accept", wr_hs, 1);
    wr_cmd_val = 1'b0;
  endtask

  initial begin
    int got, t;
    rst = 1'b1; rd_req = 0; rd_cmd_val = 0; rd_cmd_addr = '0;
    wr_req = 0; wr_cmd_val = 0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_mask = '0;
    mem_cmd_rdy = 1'b1; mem_resp_val = 0; mem_resp_data = '0;
    resp_hold = 0; inject = 0; rd_hs = 0; wr_hs = 0;

    // reset and idle
    repeat (3) cyc();
    chk("rst_grant", {grant_rd, grant_wr}, 0);
    chk("rst_cmd", {mem_cmd_val, mem_cmd_wr, rd_cmd_rdy, wr_cmd_rdy, err_unexp_resp}, 0);
    chk("rst_addr", mem_cmd_addr, 0);
    chk("rst_data", mem_cmd_data, 0);
    chk("rst_mask", mem_cmd_mask, 0);
    mem_resp_val = 1'b1; mem_resp_data = {16{32'h1234_ABCD}};
    #1;
    chk("rst_resp_val", rd_resp_val, 1);
    chk("rst_resp_data", rd_resp_data, {16{32'h1234_ABCD}});
    mem_resp_val = 1'b0;
    rst = 1'b0;
    repeat (3) cyc();
    chk("idle_grant", {grant_rd, grant_wr}, 0);
    chk("idle_err", err_unexp_resp, 0);

    // single read transaction
    rd_req = 1'b1;
    #1 chk("rd_gnt_early", grant_rd, 0);
    cyc();
    chk("rd_gnt_lat", grant_rd, 1);
    rd_burst(4, 34'h100, 10, got);
    chk("rd_burst4", got, 4);
    wait_resp("rd_resp_all");
    chk("rd_ncmd", n_rcmd, 4);
    chk("rd_nresp", n_rresp, 4);
    rd_req = 1'b0;
    cyc();
    chk("rd_release", grant_rd, 0);

    // contention fairness
    rst = 1'b1; cyc(); rst = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    cyc();
    chk("fair1_rd", {grant_rd, grant_wr}, 2'b10);
    chk("fair1_wr_blocked", wr_cmd_rdy, 0);
    rd_req = 1'b0;
    cyc();
    chk("fair1_idle", {grant_rd, grant_wr}, 2'b00);
    cyc();
    chk("fair1_wr", {grant_rd, grant_wr}, 2'b01);
    wr_one(34'h2000, {16{32'hC0DE_F00D}}, {MASK_W{1'b1}});
    wr_req = 1'b0;
    cyc();
    rd_req = 1'b1; wr_req = 1'b1;
    cyc();
    chk("fair2_wr", {grant_rd, grant_wr}, 2'b01);
    rd_cmd_val = 1'b1; rd_cmd_addr = 34'h3000;
    #1;
    chk("ungrant_rdy", rd_cmd_rdy, 0);
    chk("ungrant_val", mem_cmd_val, 0);
    rd_cmd_val = 1'b0;
    wr_req = 1'b0;
    cyc(); cyc();
    chk("fair2_rd", {grant_rd, grant_wr}, 2'b10);
    rd_req = 1'b0;
    cyc();

    // outstanding limit and drain
    rd_req = 1'b1;
    cyc();
    resp_hold = 1'b1;
    rd_burst(10, 34'h1000, 14, got);
    chk("lim_accepted", got, 8);
    chk("lim_rdy_low", rd_cmd_rdy, 0);
    wr_req = 1'b1; rd_req = 1'b0;
    cyc();
    chk("drain_enter", {grant_rd, grant_wr}, 2'b00);
    resp_hold = 1'b0;
    t = 0;
    while (exp_resp.size() != 0 && t < 30) begin
      chk("drain_no_wgnt", grant_wr, 0);
      cyc();
      t++;
    end
    chk("drain_all_resp", exp_resp.size(), 0);
    chk("drain_last_gw", grant_wr, 0);
    t = 0;
    while (!grant_wr && t < 4) begin cyc(); t++; end
    chk("drain_wgnt", grant_wr, 1);

    // masked write with backpressure
    begin
      cmd_t e;
      mem_cmd_rdy = 1'b0;
      wr_cmd_val = 1'b1; wr_cmd_addr = 34'h4040;
      wr_cmd_data = {16{32'hA5A5_3C3C}}; wr_cmd_mask = {8{8'h0F}};
      e.wr = 1'b1; e.addr = 34'h4040; e.data = {16{32'hA5A5_3C3C}}; e.mask = {8{8'h0F}};
      exp_cmd.push_back(e);
      for (int i = 0; i < 5; i++) begin
        cyc();
        chk("bp_val", mem_cmd_val, 1);
        chk("bp_rdy", wr_cmd_rdy, 0);
        chk("bp_data", mem_cmd_data, {16{32'hA5A5_3C3C}});
        chk("bp_mask", mem_cmd_mask, {8{8'h0F}});
      end
      mem_cmd_rdy = 1'b1;
      #1 chk("bp_rdy_rise", wr_cmd_rdy, 1);
      cyc();
      chk("bp_hs", wr_hs, 1);
      wr_cmd_val = 1'b0;
      chk("bp_cmd_done", exp_cmd.size(), 0);
    end
    wr_req = 1'b0;
    cyc();

    // unexpected response, sticky error
    mem_resp_val = 1'b1; mem_resp_data = {16{32'hBAD0_0001}}; inject = 1'b1;
    cyc();
    chk("err_set", err_unexp_resp, 1);
    cyc(); cyc();
    chk("err_sticky", err_unexp_resp, 1);

    // reset during RD_OWN with three reads outstanding
    rd_req = 1'b1;
    cyc();
    resp_hold = 1'b1;
    rd_burst(3, 34'h5000, 10, got);
    chk("mid_burst3", got, 3);
    chk("mid_gnt", grant_rd, 1);
    rst = 1'b1; rd_req = 1'b0;
    cyc();
    chk("mid_rst_gnt", {grant_rd, grant_wr}, 2'b00);
    chk("mid_rst_err", err_unexp_resp, 0);
    rst = 1'b0;
    mem_q.delete(); exp_resp.delete(); exp_cmd.delete();
    resp_hold = 1'b0;
    cyc();
    chk("mid_idle_err", err_unexp_resp, 0);
    // a stray response now proves the counter restarted at zero
    mem_resp_val = 1'b1; mem_resp_data = {16{32'h0BAD_0002}}; inject = 1'b1;
    cyc();
    chk("mid_cnt_zero", err_unexp_resp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
